// File: rtl/coarse_delay_ctrl.sv
// Coarse delay line sequencer: decimated clock-enable strobe plus strobe-aligned
// delay updates with blanking, driven by a four-phase req/ack handshake.
module coarse_delay_ctrl #(
  parameter int LOG2_MAX_DELAY = 4,
  parameter int DECIM_WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      run_i,
  input  logic [DECIM_WIDTH-1:0]    decim_i,
  input  logic                      delay_req_i,
  input  logic [LOG2_MAX_DELAY-1:0] delay_new_i,
  output logic                      delay_ack_o,
  output logic                      ce_o,
  output logic [LOG2_MAX_DELAY-1:0] delay_o,
  output logic                      blank_o,
  output logic                      busy_o,
  output logic [1:0]                state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [DECIM_WIDTH-1:0]    cnt_q;
  logic [LOG2_MAX_DELAY-1:0] pend_q, pend_d;
  logic [LOG2_MAX_DELAY-1:0] flush_q, flush_d;
  logic [LOG2_MAX_DELAY-1:0] delay_d;
  logic                      blank_d, ack_d, busy_d;
  logic                      wrap;

  assign state_o = state_q;
  assign wrap    = (cnt_q >= decim_i);

  // A lowered decim_i below cnt_q is caught by >= so the counter wraps at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ce_o  <= 1'b0;
    end else begin
      ce_o <= run_i && wrap;
      if (!run_i || wrap) cnt_q <= '0;
      else                cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      flush_q     <= '0;
      delay_o     <= '0;
      blank_o     <= 1'b0;
      delay_ack_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      flush_q     <= flush_d;
      delay_o     <= delay_d;
      blank_o     <= blank_d;
      delay_ack_o <= ack_d;
      busy_o      <= busy_d;
    end
  end

  // Handshake: delay_req_i rises with delay_new_i valid; delay_ack_o rises once
  // the update has settled; req falls; ack falls the edge after req is seen low.
  // Because DONE only exits on req low, IDLE never re-takes a stale request.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    flush_d = flush_q;
    delay_d = delay_o;
    blank_d = blank_o;
    ack_d   = delay_ack_o;
    busy_d  = busy_o;
    case (state_q)
      IDLE: begin
        if (delay_req_i) begin
          pend_d  = delay_new_i;
          busy_d  = 1'b1;
          state_d = (delay_new_i == delay_o) ? DONE : WAIT_CE;
        end
      end
      WAIT_CE: begin
        if (ce_o) begin
          delay_d = pend_q;
          flush_d = pend_q;
          if (pend_q == '0) begin
            ack_d   = 1'b1;
            state_d = DONE;
          end else begin
            blank_d = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (ce_o) begin
          flush_d = flush_q - 1'b1;
          if (flush_q == LOG2_MAX_DELAY'(1)) begin
            blank_d = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Entered from IDLE with ack still low: raise it first so a dropped
        // request still sees a one-cycle ack.
        if (!delay_ack_o) begin
          ack_d = 1'b1;
        end else if (!delay_req_i) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coarse_delay_ctrl.sv
// Directed bench for coarse_delay_ctrl: vector table of delay updates plus
// hand-written sequences for reset, stall, preemption, early release and reset mid-flush.
module tb_coarse_delay_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] decim;
  logic       delay_req;
  logic [3:0] delay_new;
  logic       delay_ack;
  logic       ce;
  logic [3:0] delay;
  logic       blank;
  logic       busy;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  coarse_delay_ctrl #(.LOG2_MAX_DELAY(4), .DECIM_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
    .decim_i     (decim),
    .delay_req_i (delay_req),
    .delay_new_i (delay_new),
    .delay_ack_o (delay_ack),
    .ce_o        (ce),
    .delay_o     (delay),
    .blank_o     (blank),
    .busy_o      (busy),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] decim;
    logic [3:0] dnew;
    logic [3:0] exp_delay;
    int         exp_blank;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request, run to ack, then release; reports blank cycles and
  // request-to-ack latency, and whether delay_o only moved on a strobe.
  task automatic do_update(input logic [3:0] dnew, output int blank_cnt,
                           output int lat, output bit strobe_ok);
    logic [3:0] prev_delay;
    logic       prev_ce;
    delay_req = 1'b1;
    delay_new = dnew;
    step();
    lat       = 1;
    blank_cnt = 0;
    strobe_ok = 1'b1;
    check("busy_rise", 32'(busy), 32'd1);
    prev_delay = delay;
    prev_ce    = ce;
    if (blank) blank_cnt++;
    while (!delay_ack && lat < 3000) begin
      step();
      lat++;
      if (blank) blank_cnt++;
      if (delay != prev_delay && !prev_ce) strobe_ok = 1'b0;
      prev_delay = delay;
      prev_ce    = ce;
    end
    check("ack_seen", 32'(delay_ack), 32'd1);
    check("blank_low_at_ack", 32'(blank), 32'd0);
    delay_req = 1'b0;
    step();
    check("ack_release", 32'(delay_ack), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
  endtask

  initial begin
    int blank_cnt;
    int lat;
    int n;
    bit strobe_ok;

    vecs[0] = '{8'd7, 4'd3,  4'd3,  24, -1};
    vecs[1] = '{8'd7, 4'd3,  4'd3,  0,   2};
    vecs[2] = '{8'd7, 4'd0,  4'd0,  0,  -1};
    vecs[3] = '{8'd0, 4'd15, 4'd15, 15, -1};
    vecs[4] = '{8'd2, 4'd5,  4'd5,  15, -1};
    vecs[5] = '{8'd3, 4'd1,  4'd1,  4,  -1};
    vecs[6] = '{8'd1, 4'd15, 4'd15, 30, -1};
    vecs[7] = '{8'd0, 4'd15, 4'd15, 0,   2};

    // Clock/reset
    rst_n     = 1'b0;
    run       = 1'b1;
    decim     = 8'd7;
    delay_req = 1'b0;
    delay_new = 4'd0;
    repeat (3) step();
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_delay", 32'(delay), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_ack", 32'(delay_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Strobe after edges 8, 16, 24 with decim 7
    for (int k = 1; k <= 24; k++) begin
      step();
      check($sformatf("strobe_e%0d", k), 32'(ce), 32'((k % 8) == 0));
    end

    // Table of updates
    for (int i = 0; i < 8; i++) begin
      decim = vecs[i].decim;
      step();
      do_update(vecs[i].dnew, blank_cnt, lat, strobe_ok);
      check($sformatf("v%0d_delay", i), 32'(delay), 32'(vecs[i].exp_delay));
      check($sformatf("v%0d_blank_len", i), 32'(blank_cnt), 32'(vecs[i].exp_blank));
      check($sformatf("v%0d_on_strobe", i), 32'(strobe_ok), 32'd1);
      if (vecs[i].exp_lat >= 0)
        check($sformatf("v%0d_ack_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Stall in FLUSH for 20 cycles and preemption while busy (15 -> 4)
    decim = 8'd3;
    step();
    delay_req = 1'b1;
    delay_new = 4'd4;
    step();
    delay_new = 4'd9;
    blank_cnt = 0;
    n = 0;
    while (!blank && n < 200) begin step(); n++; end
    check("stall_blank_rise", 32'(blank), 32'd1);
    if (blank) blank_cnt++;
    n = 0;
    while (!ce && n < 200) begin
      step(); n++;
      if (blank) blank_cnt++;
    end
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (blank) blank_cnt++;
    end
    check("stall_blank_held", 32'(blank), 32'd1);
    check("stall_state_flush", 32'(state), 32'd2);
    check("stall_delay_held", 32'(delay), 32'd4);
    run = 1'b1;
    n = 0;
    while (!delay_ack && n < 400) begin
      step(); n++;
      if (blank) blank_cnt++;
    end
    check("stall_ack", 32'(delay_ack), 32'd1);
    check("stall_blank_len", 32'(blank_cnt), 32'd36);
    check("preempt_delay", 32'(delay), 32'd4);
    delay_req = 1'b0;
    step();
    check("stall_release", 32'(delay_ack), 32'd0);

    // Request dropped before ack: ack is a single-cycle pulse
    decim = 8'd1;
    delay_req = 1'b1;
    delay_new = 4'd2;
    step();
    delay_req = 1'b0;
    n = 0;
    while (!delay_ack && n < 200) begin step(); n++; end
    check("early_ack", 32'(delay_ack), 32'd1);
    check("early_delay", 32'(delay), 32'd2);
    step();
    check("early_ack_pulse", 32'(delay_ack), 32'd0);
    check("early_busy", 32'(busy), 32'd0);

    // Request held high after ack: FSM stays in DONE
    decim = 8'd0;
    delay_req = 1'b1;
    delay_new = 4'd7;
    n = 0;
    step();
    while (!delay_ack && n < 200) begin step(); n++; end
    repeat (5) step();
    check("held_ack", 32'(delay_ack), 32'd1);
    check("held_state_done", 32'(state), 32'd3);
    delay_req = 1'b0;
    step();
    check("held_release", 32'(delay_ack), 32'd0);

    // Reset mid-FLUSH with request still high
    decim = 8'd3;
    delay_req = 1'b1;
    delay_new = 4'd12;
    n = 0;
    while (!blank && n < 200) begin step(); n++; end
    repeat (3) step();
    check("pre_reset_blank", 32'(blank), 32'd1);
    rst_n = 1'b0;
    delay_new = 4'd6;
    #1;
    check("mid_rst_delay", 32'(delay), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(delay_ack), 32'd0);
    check("mid_rst_ce", 32'(ce), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 32'd1);
    n = 1;
    while (!ce && n < 200) begin step(); n++; end
    check("post_rst_first_ce", 32'(n), 32'd4);
    check("post_rst_delay_old", 32'(delay), 32'd0);
    step();
    check("post_rst_delay_new", 32'(delay), 32'd6);
    check("post_rst_blank", 32'(blank), 32'd1);
    n = 0;
    while (!delay_ack && n < 400) begin step(); n++; end
    check("post_rst_ack", 32'(delay_ack), 32'd1);
    delay_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
